// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: single-beat AXI3 master bus used by cpu_axi_bridge.
//   Parameters: ID_W, ADDR_W, DATA_W (DATA_W is 32; the strobe is 4 bits wide).
//   Channels:   AR (arid/araddr/arsize/arlen/arburst/arvalid, arready)
//               R  (rid/rdata/rvalid, rready)
//               AW (awid/awaddr/awsize/awlen/awburst/awvalid, awready)
//               W  (wdata/wstrb/wlast/wvalid, wready)
//               B  (bvalid, bready)
//   Modports:   master = bridge side, slave = interconnect/memory side.
interface cpu_axi_bridge_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic [3:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic [3:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arsize, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awsize, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arsize, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: converts the core's instruction and data SRAM-like ports
// into one AXI3 master, one transaction at a time, data port has priority.
//   clk, reset            clock, synchronous active-high reset
//   inst_* / data_*       request (req/wr/size/addr/wdata), addr_ok/data_ok
//                         handshakes (combinational) and rdata (pass-through)
//   axi                   AXI3 master port (cpu_axi_bridge_if.master); all
//                         valids/readies toward the bus are registered
// Optional feature: define CPU_AXI_BRIDGE_WBUF_EN to post data writes
// (data_ok at the AW/W handshake, B response retired in the background).
module cpu_axi_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned INST_ID = 0,
  parameter int unsigned DATA_ID = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  cpu_axi_bridge_if.master  axi
);

  localparam logic [ID_W-1:0] INST_AXI_ID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DATA_AXI_ID = ID_W'(DATA_ID);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state;
  logic   src_data;   // 1: current transaction belongs to the data port
  logic   aw_done;
  logic   w_done;

  logic              accept_ok;
  logic              sel_data;
  logic              sel_inst;
  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic              aw_hs;
  logic              w_hs;
  logic              wr_fin;
  logic              rd_fin;

  // Byte-lane strobe for a word-wide bus; size 3 is treated as a word.
  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    strb_of = 4'b0001 << lane;
      2'd1:    strb_of = 4'b0011 << {lane[1], 1'b0};
      default: strb_of = 4'b1111;
    endcase
  endfunction

`ifdef CPU_AXI_BRIDGE_WBUF_EN
  logic pending_b;    // one posted write still waiting for its B response
  assign accept_ok = ~pending_b;
`else
  assign accept_ok = 1'b1;
`endif

  // Request arbitration: only in IDLE, data port first.
  assign sel_data = (state == IDLE) && accept_ok && data_req;
  assign sel_inst = (state == IDLE) && accept_ok && !data_req && inst_req;
  assign req_wr   = sel_data & data_wr;
  assign req_size = sel_data ? data_size : inst_size;
  assign req_addr = sel_data ? data_addr : inst_addr;

  assign inst_addr_ok = sel_inst;
  assign data_addr_ok = sel_data;

  // Write completes once both AW and W have handshaken, in either order.
  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;
  assign wr_fin = (state == WR_ADDR) && (aw_done | aw_hs) && (w_done | w_hs);
  assign rd_fin = (state == RD_DATA) && axi.rvalid;

  assign inst_data_ok = rd_fin && !src_data;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
  assign data_data_ok = (rd_fin && src_data) || wr_fin;
`else
  assign data_data_ok = (rd_fin && src_data) || ((state == WR_RESP) && axi.bvalid);
`endif

  assign inst_rdata = axi.rdata;
  assign data_rdata = axi.rdata;

  // Single-beat INCR bursts only.
  assign axi.arlen   = 4'd0;
  assign axi.arburst = 2'b01;
  assign axi.awlen   = 4'd0;
  assign axi.awburst = 2'b01;
  assign axi.wlast   = 1'b1;

  // Inputs intentionally ignored: inst port never writes, rid is not checked.
  logic unused_ok;
  assign unused_ok = ^{inst_wr, inst_wdata, axi.rid};

  // Transaction FSM with registered AXI outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_data    <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.arid    <= '0;
      axi.araddr  <= '0;
      axi.arsize  <= 3'd0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awid    <= '0;
      axi.awaddr  <= '0;
      axi.awsize  <= 3'd0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= 4'd0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
      pending_b   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_data || sel_inst) begin
            src_data <= sel_data;
            if (req_wr) begin
              state       <= WR_ADDR;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              axi.awid    <= DATA_AXI_ID;
              axi.awaddr  <= data_addr;
              axi.awsize  <= {1'b0, data_size};
              axi.awvalid <= 1'b1;
              axi.wdata   <= data_wdata;
              axi.wstrb   <= strb_of(data_size, data_addr[1:0]);
              axi.wvalid  <= 1'b1;
            end else begin
              state       <= RD_ADDR;
              axi.arid    <= sel_data ? DATA_AXI_ID : INST_AXI_ID;
              axi.araddr  <= req_addr;
              axi.arsize  <= {1'b0, req_size};
              axi.arvalid <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            state      <= IDLE;
          end
        end

        WR_ADDR: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (wr_fin) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi.bready <= 1'b1;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
            pending_b  <= 1'b1;
            state      <= IDLE;
`else
            state      <= WR_RESP;
`endif
          end
        end

        WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef CPU_AXI_BRIDGE_WBUF_EN
      // Posted write retires in the background; IDLE stays blocked until then.
      if (pending_b && axi.bvalid && axi.bready) begin
        pending_b  <= 1'b0;
        axi.bready <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed self-checking bench for cpu_axi_bridge.
// The bench plays the AXI slave by driving the interface inputs directly.
// Honours CPU_AXI_BRIDGE_WBUF_EN for the write-path expectations.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;

  cpu_axi_bridge_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

  cpu_axi_bridge #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .INST_ID(0), .DATA_ID(1)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data write with immediate AW/W readiness and a one-cycle B response.
  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [3:0] exp_strb, input string tag);
    data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_size = sz; data_wdata = wd;
    #1 chk({tag, "_addr_ok"}, data_addr_ok, 1);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    chk({tag, "_awvalid"}, axi.awvalid, 1);
    chk({tag, "_wvalid"}, axi.wvalid, 1);
    chk({tag, "_wstrb"}, axi.wstrb, exp_strb);
    chk({tag, "_awsize"}, axi.awsize, {1'b0, sz});
    chk({tag, "_awaddr"}, axi.awaddr, a);
    chk({tag, "_wdata"}, axi.wdata, wd);
    chk({tag, "_awid"}, axi.awid, 1);
    axi.awready = 1'b1; axi.wready = 1'b1;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
    #1 chk({tag, "_posted_ok"}, data_data_ok, 1);
`else
    #1 chk({tag, "_early_ok"}, data_data_ok, 0);
`endif
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk({tag, "_awvalid_drop"}, axi.awvalid, 0);
    chk({tag, "_bready"}, axi.bready, 1);
    axi.bvalid = 1'b1;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
    #1 chk({tag, "_b_no_ok"}, data_data_ok, 0);
`else
    #1 chk({tag, "_b_ok"}, data_data_ok, 1);
`endif
    tick();
    axi.bvalid = 1'b0;
    chk({tag, "_bready_drop"}, axi.bready, 0);
  endtask

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rid = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_wstrb", axi.wstrb, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("const_arlen", axi.arlen, 0);
    chk("const_arburst", axi.arburst, 1);
    chk("const_wlast", axi.wlast, 1);
    reset = 1'b0;

    // Single instruction read, minimum latency
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    #1 chk("r1_inst_addr_ok", inst_addr_ok, 1);
    chk("r1_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    chk("r1_arvalid", axi.arvalid, 1);
    chk("r1_arid", axi.arid, 0);
    chk("r1_arsize", axi.arsize, 2);
    chk("r1_araddr", axi.araddr, 32'hBFC0_0000);
    chk("r1_no_ok_busy", inst_addr_ok, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("r1_arvalid_drop", axi.arvalid, 0);
    chk("r1_rready", axi.rready, 1);
    axi.rvalid = 1'b1; axi.rdata = 32'h3C01_0001;
    #1 chk("r1_inst_data_ok", inst_data_ok, 1);
    chk("r1_inst_rdata", inst_rdata, 32'h3C01_0001);
    chk("r1_data_data_ok", data_data_ok, 0);
    tick();
    axi.rvalid = 1'b0;
    chk("r1_rready_drop", axi.rready, 0);

    // Simultaneous requests: data wins, inst waits for the next IDLE
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004; inst_size = 2'd2;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 2'd2;
    #1 chk("arb_data_ok", data_addr_ok, 1);
    chk("arb_inst_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0;
    chk("arb_arid", axi.arid, 1);
    chk("arb_araddr", axi.araddr, 32'h8000_1000);
    chk("arb_inst_wait", inst_addr_ok, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h1122_3344;
    #1 chk("arb_data_data_ok", data_data_ok, 1);
    chk("arb_inst_data_ok", inst_data_ok, 0);
    chk("arb_data_rdata", data_rdata, 32'h1122_3344);
    chk("arb_inst_blocked", inst_addr_ok, 0);
    tick();
    axi.rvalid = 1'b0;
    chk("arb_inst_accept", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0;
    chk("arb2_arid", axi.arid, 0);
    chk("arb2_araddr", axi.araddr, 32'hBFC0_0004);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D;
    #1 chk("arb2_inst_data_ok", inst_data_ok, 1);
    chk("arb2_inst_rdata", inst_rdata, 32'hCAFE_F00D);
    tick();
    axi.rvalid = 1'b0;

    // Strobe generation across sizes and lanes
    do_write(32'h8000_0003, 2'd0, 32'hAB00_0000, 4'b1000, "wb3");
    do_write(32'h8000_0001, 2'd0, 32'h0000_CD00, 4'b0010, "wb1");
    do_write(32'h8000_0002, 2'd1, 32'hBEEF_0000, 4'b1100, "wh2");
    do_write(32'h8000_0010, 2'd2, 32'h1234_5678, 4'b1111, "ww");
    do_write(32'h8000_0014, 2'd3, 32'h8765_4321, 4'b1111, "ws3");

    // AW/W skew: W accepted at once, AW only in the third cycle
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0020;
    data_size = 2'd2; data_wdata = 32'h5555_AAAA;
    #1 chk("sk_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    axi.wready = 1'b1;
    chk("sk_c1_awvalid", axi.awvalid, 1);
    chk("sk_c1_wvalid", axi.wvalid, 1);
    tick();
    axi.wready = 1'b0;
    chk("sk_c2_wvalid", axi.wvalid, 0);
    chk("sk_c2_awvalid", axi.awvalid, 1);
    chk("sk_c2_bready", axi.bready, 0);
    #1 chk("sk_c2_no_ok", data_data_ok, 0);
    tick();
    chk("sk_c3_awvalid", axi.awvalid, 1);
    chk("sk_c3_bready", axi.bready, 0);
    axi.awready = 1'b1;
`ifdef CPU_AXI_BRIDGE_WBUF_EN
    #1 chk("sk_posted_ok", data_data_ok, 1);
`endif
    tick();
    axi.awready = 1'b0;
    chk("sk_awvalid_drop", axi.awvalid, 0);
    chk("sk_bready", axi.bready, 1);
`ifdef CPU_AXI_BRIDGE_WBUF_EN
    // Read stays blocked until the posted write's B response retires
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0020; data_size = 2'd2;
    #1 chk("wb_block1", data_addr_ok, 0);
    tick();
    chk("wb_block2", data_addr_ok, 0);
    axi.bvalid = 1'b1;
    #1 chk("wb_block3", data_addr_ok, 0);
    chk("wb_b_no_ok", data_data_ok, 0);
    tick();
    axi.bvalid = 1'b0;
    chk("wb_bready_drop", axi.bready, 0);
    chk("wb_unblock", data_addr_ok, 1);
    tick();
    data_req = 1'b0;
    chk("wb_rd_arvalid", axi.arvalid, 1);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h5555_AAAA;
    #1 chk("wb_rd_ok", data_data_ok, 1);
    tick();
    axi.rvalid = 1'b0;
`else
    axi.bvalid = 1'b1;
    #1 chk("sk_b_ok", data_data_ok, 1);
    tick();
    axi.bvalid = 1'b0;
    chk("sk_bready_drop", axi.bready, 0);
`endif

    // Reset during RD_DATA abandons the read
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; inst_size = 2'd2;
    #1 chk("rr_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rr_rready_pre", axi.rready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_arvalid", axi.arvalid, 0);
    chk("rr_rready", axi.rready, 0);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    #1 chk("rr_idle_accept", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0;
    chk("rr_araddr", axi.araddr, 32'hBFC0_0200);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h0000_00FF;
    #1 chk("rr_data_ok", inst_data_ok, 1);
    tick();
    axi.rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the core's two SRAM-like master ports (instruction fetch, data access) into a single AXI3 master port, with a one-transaction-at-a-time arbiter and a parametrised ID/width scheme. It sits directly below the five-stage pipeline top, between `inst_sram_*`/`data_sram_*`-style request/handshake ports and the SoC AXI crossbar. It replaces tightly coupled SRAM timing with variable-latency addr_ok/data_ok handshakes, which allows the pipeline to run against real memory.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; must be 32 (strobe logic is word-based)
- ID_W, 4, AXI ID width
- INST_ID, 0, arid used for instruction reads
- DATA_ID, 1, arid/awid used for data accesses

Ports (pairs written inst_x/data_x share direction and width):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req/data_req  in  1  request valid
- inst_wr/data_wr  in  1  1=write (inst_wr is tied 0 by the core and ignored)
- inst_size/data_size  in  2  0=byte, 1=half, 2=word
- inst_addr/data_addr  in  ADDR_W  byte address
- inst_wdata/data_wdata  in  DATA_W  write data, already lane-aligned
- inst_addr_ok/data_addr_ok  out  1  request accepted this cycle
- inst_data_ok/data_data_ok  out  1  read data valid / write done
- inst_rdata/data_rdata  out  DATA_W  read data
- arid, araddr, arsize, arvalid / arready  out, out, out, out / in  ID_W, ADDR_W, 3, 1 / 1  AR channel; arlen=0, arburst=INCR are driven as constants
- rid, rdata, rvalid / rready  in / out  ID_W, DATA_W, 1 / 1  R channel
- awid, awaddr, awsize, awvalid / awready  out / in  ID_W, ADDR_W, 3, 1 / 1  AW channel
- wdata, wstrb, wvalid / wready  out / in  DATA_W, 4, 1 / 1  W channel; wlast=1 is driven as a constant
- bvalid / bready  in / out  1 / 1  B channel

## Operation
- The FSM has the states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE: if data_req=1, data is selected; otherwise inst_req=1 selects inst (fixed priority, data first).
  - The selected port's addr_ok is asserted combinationally in that cycle.
  - addr, size, wr, wdata and the source are latched.
  - Next state is RD_ADDR for a read and WR_ADDR for a write.
  - The unselected port's addr_ok stays 0.
- RD_ADDR: arvalid=1 until arready=1, then the FSM moves to RD_DATA. arid=INST_ID or DATA_ID by source; arsize={1'b0,size}.
- RD_DATA: rready=1. On rvalid=1, the source's data_ok=1 and source rdata=rdata (combinational pass-through), and the FSM returns to IDLE. rid is not checked.
- WR_ADDR: awvalid and wvalid are raised together, and each drops independently on its handshake (aw_done/w_done flags). The FSM goes to WR_RESP when both have completed.
- wstrb encoding:
  - size0: 4'b0001<<addr[1:0]
  - size1: 4'b0011<<{addr[1],1'b0}
  - size2: 4'b1111
  - size3: 4'b1111 (treated as word)
- WR_RESP: bready=1. On bvalid=1, data_data_ok=1 and the FSM returns to IDLE. bresp is ignored.
- At most one AXI transaction is outstanding, and addr_ok is never asserted outside IDLE.
- Reset: the FSM goes to IDLE and the done flags clear.
- All outputs reset to 0: every *valid/*ready, addr_ok, data_ok. Address/data/strobe registers are 0.
- Reset mid-transaction abandons the transaction. The SoC resets the slave simultaneously.

## Timing
- Minimum read latency, from the addr_ok cycle to the data_ok cycle, is 2 cycles: arvalid in cycle +1 with arready=1, rvalid in cycle +2.
- Minimum write latency is 2 cycles: AW and W in +1, bvalid in +2.
- A back-to-back request can be accepted in the same cycle data_ok asserts? No. IDLE is entered the cycle after data_ok, so the minimum request spacing is 3 cycles.
- All AXI valids are registered outputs. addr_ok and data_ok are combinational. rdata passes through with no added latency.
- valid stays asserted with stable payload until its ready; the bridge never withdraws a valid.

## Configuration
- CPU_AXI_BRIDGE_WBUF_EN is a posted-write buffer.
- When defined:
  - A data write signals data_data_ok in the cycle its last AW/W handshake completes, and the FSM returns to IDLE.
  - One B response may be outstanding; a pending_b flag sets on that handshake and clears on bvalid&bready. bready=1 while pending_b.
  - While pending_b=1, IDLE does not accept any new request (reads or writes), so ordering is preserved.
- When undefined: behaviour is exactly as in Operation (data_ok on B).

## Test plan
- Single inst read: inst_req, addr 0xBFC00000, size 2 -> inst_addr_ok same cycle; arvalid next cycle with arid=0, arsize=2; rdata=0x3C010001 returned -> inst_data_ok=1, inst_rdata=0x3C010001 in that cycle.
- Simultaneous inst_req and data read in IDLE -> data_addr_ok=1, inst_addr_ok=0; inst is accepted in the first IDLE after data_data_ok.
- Byte write, addr 0x...03, wdata 0xAB000000 -> wstrb=4'b1000, awsize=0.
- Halfword write at 0x...02 -> wstrb=4'b1100.
- AW and W skew: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid is held 3 cycles, WR_RESP is entered after the later handshake.
- Reset asserted during RD_DATA -> next cycle arvalid=rready=0, state IDLE; with WBUF_EN, a write's data_ok precedes bvalid, and a following read is blocked until bvalid&bready.
